// File: rtl/bp_pkg.sv
// Shared constants and PC slicing helpers for the branch target buffer.
// Latency: n/a (pure functions). Backpressure: n/a.
// Everything here is combinational and is elaborated into the modules that import it.
package bp_pkg;

    typedef logic [31:0] pc_t;

    // Counter value one below the taken threshold: weakly not taken.
    function automatic int unsigned ctr_weak_nt(input int unsigned bits);
        return (32'd1 << (bits - 32'd1)) - 32'd1;
    endfunction

    // Lowest counter value that predicts taken.
    function automatic int unsigned ctr_weak_t(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

    // Saturation ceiling of the direction counter.
    function automatic int unsigned ctr_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // Word-aligned table index: PC[idx_bits+1:2].
    function automatic pc_t pc_index(input pc_t pc, input int unsigned idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag taken from the bits directly above the index.
    function automatic pc_t pc_tag(input pc_t pc, input int unsigned idx_bits,
                                   input int unsigned tag_bits);
        return (pc >> (idx_bits + 32'd2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_sat_counter.sv
// Saturating up/down next-value logic for one direction counter.
// Latency: combinational. Backpressure: none.
// force_max overrides the direction and pins the counter at its ceiling.
module branch_sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_cur,
    input  logic                inc,
    input  logic                force_max,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    localparam logic [CTR_BITS-1:0] CTR_TOP = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    // Step toward the requested direction, holding at either end.
    always_comb begin
        ctr_nxt = ctr_cur;
        if (force_max) begin
            ctr_nxt = CTR_TOP;
        end else if (inc) begin
            if (ctr_cur != CTR_TOP) ctr_nxt = ctr_cur + CTR_ONE;
        end else begin
            if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_ONE;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters; decode-side training and mispredict report.
// Latency: lookup and mispredict are combinational; table updates land on the next clock edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Flush,
    input  logic [31:0] PCFetch,
    output logic        PredictTaken,
    output logic [31:0] PredictTarget,
    input  logic        UpdateValid,
    input  logic        UpdateUncond,
    input  logic [31:0] UpdatePC,
    input  logic        UpdateTaken,
    input  logic [31:0] UpdateTarget,
    input  logic        PredTakenIn,
    input  logic [31:0] PredTargetIn,
    output logic        Mispredict,
    output logic [31:0] RecoverPC,
    output logic [31:0] LookupCount,
    output logic [31:0] MispredictCount
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [31:0]         STAT_MAX = 32'hFFFF_FFFF;

    // Table state: valid kept as a flat vector so Flush/Reset clear it in one edge.
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX-1:0]      f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                f_hit, u_hit;
    logic [CTR_BITS-1:0] u_ctr_nxt;

    assign f_idx = IDX'(pc_index(PCFetch, IDX));
    assign f_tag = TAG_BITS'(pc_tag(PCFetch, IDX, TAG_BITS));
    assign u_idx = IDX'(pc_index(UpdatePC, IDX));
    assign u_tag = TAG_BITS'(pc_tag(UpdatePC, IDX, TAG_BITS));

    // Fetch lookup against the current table; suppressed while Reset is held.
    always_comb begin
        f_hit         = !Reset && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        PredictTaken  = f_hit && ctr_q[f_idx][CTR_BITS-1];
        PredictTarget = f_hit ? target_q[f_idx] : PCFetch + 32'd4;
    end

    // Resolved outcome versus the prediction carried down from fetch.
    always_comb begin
        u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        Mispredict = UpdateValid &&
                     ((PredTakenIn != UpdateTaken) ||
                      (UpdateTaken && (PredTargetIn != UpdateTarget)));
        RecoverPC  = UpdateTaken ? UpdateTarget : UpdatePC + 32'd4;
    end

    branch_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_upd_ctr (
        .ctr_cur   (ctr_q[u_idx]),
        .inc       (UpdateTaken),
        .force_max (UpdateUncond),
        .ctr_nxt   (u_ctr_nxt)
    );

    // Training: Flush discards the whole update; a taken miss replaces the slot.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (Flush) begin
            valid_d = '0;
        end else if (UpdateValid) begin
            if (u_hit) begin
                ctr_d[u_idx] = u_ctr_nxt;
                if (UpdateTaken) target_d[u_idx] = UpdateTarget;
            end else if (UpdateTaken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = UpdateTarget;
                ctr_d[u_idx]    = UpdateUncond ? CTR_MAX : WEAK_T;
            end
        end
    end

    // Hit and mispredict statistics, pinned at all-ones rather than wrapping.
    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (f_hit && (lookup_cnt_q != STAT_MAX))      lookup_cnt_d  = lookup_cnt_q + 32'd1;
        if (Mispredict && (mispred_cnt_q != STAT_MAX)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    // Valid bits, counters and stats: Reset overrides every other write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q       <= '0;
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
        end else begin
            valid_q       <= valid_d;
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            ctr_q         <= ctr_d;
        end
    end

    // Tag and target payload; only meaningful behind a valid bit, so never reset.
    always_ff @(posedge Clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign LookupCount     = lookup_cnt_q;
    assign MispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with an array-based reference model.
// Latency: model mirrors the edge-visible table and the combinational lookup.
// Backpressure: none; one stimulus vector per cycle.
module tb_branch_predictor;

    localparam int ENTRIES  = 64;
    localparam int TAG_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int M_WNT    = (1 << (CTR_BITS - 1)) - 1;
    localparam int M_WT     = 1 << (CTR_BITS - 1);
    localparam int M_MAX    = (1 << CTR_BITS) - 1;
    localparam logic [31:0] IDLE_PC = 32'h0000_1000;

    logic        Clk = 1'b0;
    logic        Reset, Flush, UpdateValid, UpdateUncond, UpdateTaken, PredTakenIn;
    logic [31:0] PCFetch, UpdatePC, UpdateTarget, PredTargetIn;
    logic        PredictTaken, Mispredict;
    logic [31:0] PredictTarget, RecoverPC, LookupCount, MispredictCount;

    always #5 Clk = ~Clk;

    branch_predictor #(
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS),
        .CTR_BITS (CTR_BITS)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Flush           (Flush),
        .PCFetch         (PCFetch),
        .PredictTaken    (PredictTaken),
        .PredictTarget   (PredictTarget),
        .UpdateValid     (UpdateValid),
        .UpdateUncond    (UpdateUncond),
        .UpdatePC        (UpdatePC),
        .UpdateTaken     (UpdateTaken),
        .UpdateTarget    (UpdateTarget),
        .PredTakenIn     (PredTakenIn),
        .PredTargetIn    (PredTargetIn),
        .Mispredict      (Mispredict),
        .RecoverPC       (RecoverPC),
        .LookupCount     (LookupCount),
        .MispredictCount (MispredictCount)
    );

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_lk, m_mp;
    bit          m_init = 1'b0;

    function automatic int unsigned midx(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic bit exp_pt();
        return !Reset && m_hit(PCFetch) && (m_ctr[midx(PCFetch)] >= M_WT);
    endfunction

    function automatic logic [31:0] exp_tgt();
        return (!Reset && m_hit(PCFetch)) ? m_tgt[midx(PCFetch)] : PCFetch + 32'd4;
    endfunction

    function automatic bit exp_mis();
        return UpdateValid && ((PredTakenIn != UpdateTaken) ||
                               (UpdateTaken && (PredTargetIn != UpdateTarget)));
    endfunction

    function automatic logic [31:0] exp_rec();
        return UpdateTaken ? UpdateTarget : UpdatePC + 32'd4;
    endfunction

    always @(posedge Clk) begin
        int unsigned ui;
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = M_WNT;
            end
            m_lk   = 32'd0;
            m_mp   = 32'd0;
            m_init = 1'b1;
        end else begin
            if (m_hit(PCFetch) && m_lk != 32'hFFFF_FFFF) m_lk = m_lk + 32'd1;
            if (exp_mis() && m_mp != 32'hFFFF_FFFF)      m_mp = m_mp + 32'd1;
            ui = midx(UpdatePC);
            if (Flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            end else if (UpdateValid) begin
                if (m_hit(UpdatePC)) begin
                    if (UpdateUncond)     m_ctr[ui] = M_MAX;
                    else if (UpdateTaken) m_ctr[ui] = (m_ctr[ui] < M_MAX) ? m_ctr[ui] + 1 : M_MAX;
                    else                  m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                    if (UpdateTaken) m_tgt[ui] = UpdateTarget;
                end else if (UpdateTaken) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = mtag(UpdatePC);
                    m_tgt[ui]   = UpdateTarget;
                    m_ctr[ui]   = UpdateUncond ? M_MAX : M_WT;
                end
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } lit_t;

    lit_t lq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return {31'd0, PredictTaken};
            1:       return PredictTarget;
            2:       return {31'd0, Mispredict};
            3:       return RecoverPC;
            4:       return LookupCount;
            default: return MispredictCount;
        endcase
    endfunction

    // Every cycle: DUT against model; then any hand-computed literals queued for this cycle.
    always @(negedge Clk) begin
        lit_t l;
        check("pred_taken",  {31'd0, PredictTaken}, {31'd0, exp_pt()});
        check("pred_target", PredictTarget, exp_tgt());
        check("mispredict",  {31'd0, Mispredict}, {31'd0, exp_mis()});
        check("recover_pc",  RecoverPC, exp_rec());
        if (m_init) begin
            check("lookup_count",     LookupCount, m_lk);
            check("mispredict_count", MispredictCount, m_mp);
        end
        while (lq.size() > 0) begin
            l = lq.pop_front();
            check(l.name, pick(l.sel), l.exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string name, input int sel, input logic [31:0] exp);
        lq.push_back('{name, sel, exp});
    endtask

    task automatic idle(input logic [31:0] pc);
        Reset        = 1'b0;
        Flush        = 1'b0;
        UpdateValid  = 1'b0;
        UpdateUncond = 1'b0;
        UpdateTaken  = 1'b0;
        PredTakenIn  = 1'b0;
        UpdatePC     = 32'h0;
        UpdateTarget = 32'h0;
        PredTargetIn = 32'h0;
        PCFetch      = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic unc);
        idle(IDLE_PC);
        UpdateValid  = 1'b1;
        UpdatePC     = pc;
        UpdateTaken  = tk;
        UpdateTarget = tgt;
        PredTakenIn  = ptk;
        PredTargetIn = ptgt;
        UpdateUncond = unc;
    endtask

    initial begin
        idle(32'h40);
        Reset = 1'b1;
        tick();
        lit("rst_pt", 0, 32'h0);
        lit("rst_tgt", 1, 32'h44);
        tick();

        idle(32'h40);
        lit("post_rst_pt", 0, 32'h0);
        lit("post_rst_tgt", 1, 32'h44);
        lit("post_rst_lk", 4, 32'd0);
        lit("post_rst_mp", 5, 32'd0);
        tick();

        // First allocation of 0x40 -> 0x80.
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        lit("alloc_mis", 2, 32'd1);
        lit("alloc_rec", 3, 32'h80);
        tick();
        idle(32'h40);
        lit("hit_pt", 0, 32'd1);
        lit("hit_tgt", 1, 32'h80);
        tick();
        upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        lit("hit_lk", 4, 32'd1);
        lit("correct_mis", 2, 32'd0);
        tick();
        repeat (2) begin
            upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
            tick();
        end

        // Saturated at 3; two not-taken steps walk it down to 1.
        upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
        lit("nt_rec", 3, 32'h44);
        tick();
        idle(32'h40);
        lit("ctr2_pt", 0, 32'd1);
        tick();
        upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
        tick();
        idle(32'h40);
        lit("ctr1_pt", 0, 32'd0);
        lit("ctr1_tgt", 1, 32'h80);
        tick();

        // Aliasing: 0x140 shares index 16 with 0x40.
        upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        lit("pre_alias_lk", 4, 32'd3);
        lit("pre_alias_mp", 5, 32'd3);
        tick();
        idle(32'h40);
        lit("alias_old_pt", 0, 32'd0);
        lit("alias_old_tgt", 1, 32'h44);
        tick();
        idle(32'h140);
        lit("alias_new_pt", 0, 32'd1);
        lit("alias_new_tgt", 1, 32'h200);
        tick();

        // Mispredict flavours at 0x20.
        upd(32'h20, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        lit("mis_nt_t", 2, 32'd1);
        lit("rec_t", 3, 32'h100);
        lit("mp_before", 5, 32'd4);
        tick();
        upd(32'h20, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0);
        lit("mis_t_nt", 2, 32'd1);
        lit("rec_nt", 3, 32'h24);
        lit("mp_after", 5, 32'd5);
        tick();
        upd(32'h20, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0);
        lit("mis_wrong_tgt", 2, 32'd1);
        tick();
        upd(32'h20, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        lit("mis_none", 2, 32'd0);
        lit("mp_7", 5, 32'd7);
        tick();

        // Same-cycle lookup and allocate: lookup sees the old table.
        upd(32'h300, 1'b1, 32'h380, 1'b0, 32'h0, 1'b0);
        PCFetch = 32'h300;
        lit("nobypass_pt", 0, 32'd0);
        lit("nobypass_tgt", 1, 32'h304);
        tick();
        idle(32'h300);
        lit("after_alloc_pt", 0, 32'd1);
        lit("after_alloc_tgt", 1, 32'h380);
        tick();

        // Unconditional allocation starts at max: one not-taken still predicts taken.
        upd(32'h504, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1);
        tick();
        upd(32'h504, 1'b0, 32'h600, 1'b1, 32'h600, 1'b0);
        tick();
        idle(32'h504);
        lit("uncond_pt", 0, 32'd1);
        lit("uncond_tgt", 1, 32'h600);
        tick();

        // Flush together with an allocating update.
        upd(32'h400, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        Flush = 1'b1;
        tick();
        idle(32'h400);
        lit("flush_new_pt", 0, 32'd0);
        lit("flush_new_tgt", 1, 32'h404);
        tick();
        idle(32'h140);
        lit("flush_old_pt", 0, 32'd0);
        tick();
        idle(32'h20);
        lit("flush_old2_tgt", 1, 32'h24);
        tick();

        // Reset mid-training, combined with Flush and an allocating update.
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        tick();
        idle(32'h40);
        lit("retrain_pt", 0, 32'd1);
        tick();
        upd(32'h80, 1'b1, 32'h90, 1'b0, 32'h0, 1'b0);
        Reset   = 1'b1;
        Flush   = 1'b1;
        PCFetch = 32'h40;
        lit("in_rst_pt", 0, 32'd0);
        lit("in_rst_tgt", 1, 32'h44);
        tick();
        idle(32'h40);
        lit("rst2_pt", 0, 32'd0);
        lit("rst2_tgt", 1, 32'h44);
        lit("rst2_lk", 4, 32'd0);
        lit("rst2_mp", 5, 32'd0);
        tick();
        idle(32'h80);
        lit("rst2_alloc_pt", 0, 32'd0);
        lit("rst2_alloc_tgt", 1, 32'h84);
        tick();

        idle(IDLE_PC);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
